// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the mux_arbiter block.
//   state_t      : arbiter FSM encoding (IDLE / GRANT_A / GRANT_B)
//   SEL_A, SEL_B : mux select values steering requester A or B
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_mux2.sv
// Single-bit 2:1 mux cell shared by the arbiter datapath.
//   out : selected bit
//   a   : input chosen when sel = 0
//   b   : input chosen when sel = 1
//   sel : select
module mux_arbiter_mux2 (
  output logic out,
  input  logic a,
  input  logic b,
  input  logic sel
);

  assign out = sel ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux datapath between requesters A and B.
// A grant is held until the granted requester's last beat is accepted; steered
// beats land in a one-entry valid/ready output register.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_x, data_x, last_x      : requester beat (x = a, b)
//   ready_x                    : beat from x accepted when req_x & ready_x
//   out_valid/out_data/out_last: registered output beat
//   out_ready                  : sink accepts when out_valid & out_ready
//   sel                        : mux select (0 = A, 1 = B)
//   busy                       : a grant is active
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              last_a,
  output logic              ready_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              last_b,
  output logic              ready_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  state_t            state;
  state_t            next_state;
  logic              prio;
  logic              slot_free;
  logic              accept;
  logic [DATA_W:0]   mux_in_a;
  logic [DATA_W:0]   mux_in_b;
  logic [DATA_W:0]   mux_out;

  // Payload and last flag travel together; bit DATA_W is the last flag.
  assign mux_in_a  = {last_a, data_a};
  assign mux_in_b  = {last_b, data_b};
  assign slot_free = !out_valid || out_ready;
  assign accept    = (req_a && ready_a) || (req_b && ready_b);

  for (genvar i = 0; i <= DATA_W; i++) begin : g_mux
    mux_arbiter_mux2 u_mux (
      .out (mux_out[i]),
      .a   (mux_in_a[i]),
      .b   (mux_in_b[i]),
      .sel (sel)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // sel already points at the granted requester, so the mux output's last
  // bit is the granted requester's last flag.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !prio)) begin
          next_state = GRANT_A;
        end else if (req_b) begin
          next_state = GRANT_B;
        end
      end
      GRANT_A, GRANT_B: begin
        if (accept && mux_out[DATA_W]) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready_a = (state == GRANT_A) && slot_free;
    ready_b = (state == GRANT_B) && slot_free;
    busy    = (state != IDLE);
  end

  // sel changes only when a grant is issued; prio flips to the other
  // requester when a grant ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= SEL_A;
      prio <= 1'b0;
    end else begin
      if (state == IDLE && next_state != IDLE) begin
        sel <= (next_state == GRANT_B) ? SEL_B : SEL_A;
      end
      if (state != IDLE && next_state == IDLE) begin
        prio <= (state == GRANT_A);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux_out[DATA_W-1:0];
      out_last  <= mux_out[DATA_W];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_a = 1'b0;
  logic [DW-1:0] data_a = '0;
  logic          last_a = 1'b0;
  logic          ready_a;
  logic          req_b = 1'b0;
  logic [DW-1:0] data_b = '0;
  logic          last_b = 1'b0;
  logic          ready_b;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          sel;
  logic          busy;

  always #5 clk = ~clk;

  mux_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .last_a    (last_a),
    .ready_a   (ready_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .last_b    (last_b),
    .ready_b   (ready_b),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  // Pending beats per source ({last, data}), beats in flight to the sink,
  // and the order in which packets completed (1 = A, 2 = B).
  logic [DW:0] qa[$];
  logic [DW:0] qb[$];
  logic [DW:0] exp_q[$];
  int          order[$];

  // Reference model: who owns the mux, whose turn it is, output slot.
  int          grant = 0;
  logic        prio = 1'b0;
  logic        m_sel = 1'b0;
  logic        m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;
  logic        m_ol = 1'b0;

  int unsigned pct_a = 100;
  int unsigned pct_b = 100;
  int unsigned pct_rdy = 100;
  int          hold_a = 0;
  int          stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int src, input logic [DW-1:0] d, input logic l);
    if (src == 1) qa.push_back({l, d});
    else          qb.push_back({l, d});
  endtask

  task automatic add_pkt(input int src, input int len);
    for (int j = 0; j < len; j++) add_beat(src, DW'($urandom), j == len - 1);
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); exp_q.delete(); order.delete();
    grant = 0; prio = 1'b0; m_sel = 1'b0;
    m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
    hold_a = 0; stall = 0;
  endtask

  // Asynchronous reset asserted between clock edges, checked right away.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_sel",       32'(sel),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ready_a",   32'(ready_a),   32'd0);
    check("rst_ready_b",   32'(ready_b),   32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic          ra, rb, orr, mra, mrb, aa, ab;
    logic [DW:0]   beat;
    logic [DW:0]   snap;
    @(negedge clk);
    check("sel",       32'(sel),       32'(m_sel));
    check("busy",      32'(busy),      32'(grant != 0));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_last", 32'(out_last), 32'(m_ol));
    end
    ra  = (qa.size() != 0) && (hold_a == 0) && ($urandom_range(99) < pct_a);
    rb  = (qb.size() != 0) && ($urandom_range(99) < pct_b);
    orr = (stall == 0) && ($urandom_range(99) < pct_rdy);
    req_a = ra;
    {last_a, data_a} = ra ? qa[0] : (DW+1)'($urandom);
    req_b = rb;
    {last_b, data_b} = rb ? qb[0] : (DW+1)'($urandom);
    out_ready = orr;
    if (hold_a > 0) hold_a--;
    if (stall > 0)  stall--;
    mra = (grant == 1) && (!m_ov || orr);
    mrb = (grant == 2) && (!m_ov || orr);
    #1;
    check("ready_a", 32'(ready_a), 32'(mra));
    check("ready_b", 32'(ready_b), 32'(mrb));
    snap = {out_last, out_data};
    aa = ra && mra;
    ab = rb && mrb;
    @(posedge clk);
    if (m_ov && orr) begin
      if (exp_q.size() == 0) check("sink_extra", 32'd1, 32'd0);
      else check("sink_beat", 32'(snap), 32'(exp_q.pop_front()));
    end
    beat = '0;
    if (aa) begin
      beat = qa.pop_front();
      exp_q.push_back(beat);
    end else if (ab) begin
      beat = qb.pop_front();
      exp_q.push_back(beat);
    end
    if (aa || ab) begin
      m_ov = 1'b1; m_od = beat[DW-1:0]; m_ol = beat[DW];
    end else if (orr) begin
      m_ov = 1'b0;
    end
    if (grant == 0) begin
      if (ra && (!rb || !prio)) begin
        grant = 1; m_sel = 1'b0;
      end else if (rb) begin
        grant = 2; m_sel = 1'b1;
      end
    end else if ((aa || ab) && beat[DW]) begin
      order.push_back(grant);
      prio  = (grant == 1);
      grant = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic full_rate();
    pct_a = 100; pct_b = 100; pct_rdy = 100;
  endtask

  initial begin
    async_reset();

    // Single 3-beat packet from A.
    full_rate();
    add_beat(1, 16'h0011, 1'b0);
    add_beat(1, 16'h0022, 1'b0);
    add_beat(1, 16'h0033, 1'b1);
    run(8);
    check("single_pkts", 32'(order.size()), 32'd1);

    // Contention from reset: strict alternation starting with A.
    async_reset();
    for (int i = 0; i < 4; i++) begin
      add_pkt(1, 1);
      add_pkt(2, 1);
    end
    run(24);
    check("cont_pkts", 32'(order.size()), 32'd8);
    if (order.size() == 8)
      for (int i = 0; i < 8; i++) check("cont_order", 32'(order[i]), (i % 2) ? 32'd2 : 32'd1);

    // Back-pressure in the middle of an A packet.
    async_reset();
    add_pkt(1, 6);
    run(3);
    stall = 4;
    run(14);
    check("bp_pkts", 32'(order.size()), 32'd1);

    // Grant hold: A pauses mid-packet while B keeps requesting.
    async_reset();
    add_pkt(1, 4);
    add_pkt(2, 2);
    run(3);
    hold_a = 3;
    run(16);
    check("hold_pkts", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      check("hold_first", 32'(order[0]), 32'd1);
      check("hold_second", 32'(order[1]), 32'd2);
    end

    // Full-width extremes from B.
    async_reset();
    add_beat(2, 16'hFFFF, 1'b0);
    add_beat(2, 16'h0000, 1'b1);
    run(8);
    check("width_pkts", 32'(order.size()), 32'd1);

    // Reset in the middle of a B packet, then a fresh A packet.
    async_reset();
    add_pkt(2, 5);
    run(3);
    async_reset();
    add_pkt(1, 2);
    run(8);
    check("post_rst_pkts", 32'(order.size()), 32'd1);
    if (order.size() == 1) check("post_rst_src", 32'(order[0]), 32'd1);

    // Randomized traffic, rates and stalls.
    async_reset();
    for (int it = 0; it < 60; it++) begin
      if (qa.size() < 6) add_pkt(1, int'($urandom_range(4, 1)));
      if (qb.size() < 6) add_pkt(2, int'($urandom_range(4, 1)));
      pct_a   = $urandom_range(100, 40);
      pct_b   = $urandom_range(100, 40);
      pct_rdy = $urandom_range(100, 30);
      if ($urandom_range(3) == 0) hold_a = int'($urandom_range(4, 1));
      if ($urandom_range(3) == 0) stall  = int'($urandom_range(4, 1));
      run(10);
    end
    full_rate();
    hold_a = 0;
    stall = 0;
    run(120);
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);
    check("drain_sink", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin controller that shares one 2:1 mux datapath between two packet requesters, A and B. It grants one requester at a time and holds the grant until that requester's last beat is accepted. It drives the mux select and registers the steered beat into a one-entry output stage with a valid/ready handshake. It sits upstream of any single-consumer sink that both sources must reach.

## Interface
- DATA_W, 8, beat payload width in bits

- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_a  in  1  requester A has a valid beat
- data_a  in  DATA_W  requester A payload
- last_a  in  1  final beat of A's packet
- ready_a  out  1  A's beat accepted this cycle when req_a & ready_a
- req_b, data_b, last_b  in  1/DATA_W/1  same as A, for requester B
- ready_b  out  1  same as ready_a, for B
- out_valid  out  1  output register holds a beat
- out_data  out  DATA_W  registered payload
- out_last  out  1  registered last flag
- out_ready  in  1  sink accepts the beat when out_valid & out_ready
- sel  out  1  mux select: 0 = A, 1 = B
- busy  out  1  a grant is active (state != IDLE)

## Operation
- FSM states: IDLE, GRANT_A, GRANT_B.
- prio register: 0 favours A, 1 favours B.
- IDLE transitions:
  - req_a only -> GRANT_A.
  - req_b only -> GRANT_B.
  - Both -> GRANT_A if prio=0, else GRANT_B.
  - Neither -> stay in IDLE.
- sel updates on entry to a grant state and is held until the next grant; it is held in IDLE as well.
- ready_x = (state == GRANT_x) & (!out_valid | out_ready). The non-granted ready is 0.
- Beat accepted (req_x & ready_x) -> out_data/out_last load the mux output and out_valid is set.
- out_valid & out_ready with no new accept -> out_valid clears.
- Load and drain in the same cycle are allowed, giving full throughput.
- Accepted beat with last_x=1 -> next state is IDLE, and prio is set to point at the other requester.
- Granted requester drops req mid-packet -> the grant is held with no timeout. The other requester waits.
- Data steering: (sel ? b : a) through the shared 2:1 mux cell.
- Reset values: state=IDLE, prio=0, sel=0, busy=0, ready_a=ready_b=0, out_valid=0, out_data=0, out_last=0.
- Reset mid-packet: everything returns to the reset values immediately. An in-flight beat in the output register is discarded.

## Timing
- Arbitration: a request seen in IDLE at edge n gives the grant (sel, busy) after edge n. The first ready is possible in cycle n+1.
- No beat is accepted in IDLE.
- Beat latency: accepted at edge k -> out_valid=1 after edge k.
- Packet turnaround: the last beat is accepted at edge k; IDLE in cycle k+1; the next grant after edge k+1. There is 1 idle cycle between packets.
- Back-pressure: while out_valid=1 and out_ready=0, ready of the granted requester is 0. out_data is held stable.
- ready_x is combinational from state, out_valid and out_ready. There is no combinational path from req_x to ready_x.

## Structure
- Package mux_arbiter_pkg holds:
  - the state enum (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2);
  - the SEL_A=1'b0 and SEL_B=1'b1 constants.
- Sub-module: the existing mux cell, with port order (out, a, b, sel).
  - Instantiated via generate, one per data bit plus one for last.
  - All instances share the registered sel.
- FSM, prio and the output register live in the top module.

## Test plan
- Single packet: A sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready=1. Required: out_data 0x11, 0x22, 0x33 on consecutive cycles starting 2 cycles after req_a; sel=0 throughout; then busy=0.
- Contention: req_a=req_b=1 from reset, 1-beat packets each. Required order A, B, A, B; sel toggles; prio flips after each last.
- Back-pressure: during an A packet, hold out_ready=0 for 4 cycles. Required: ready_a=0 and out_data held constant; no beat lost or duplicated; resumes on release.
- Grant hold: A drops req_a mid-packet for 3 cycles while req_b=1. Required: sel stays 0, ready_b=0, and A completes before B is granted.
- Reset mid-packet: assert rst_n=0 asynchronously between edges during a B packet. Required: out_valid=0, sel=0, busy=0 immediately; after release, a new A request is granted normally.
- Width: DATA_W=16, send 0xFFFF then 0x0000 from B. Required: exact values reach out_data.
